writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Parametrised next-generation writeback stage for the riscvga pipeline.
- Accepts one instruction per cycle from execute over a valid/ready handshake and selects the destination value from NUM_SRC_P result sources.
- Registers the register-file write and resolves branches/jumps into a one-cycle redirect.
- After a taken redirect, squashes the FLUSH_CYCLES_P following wrong-path instructions.

Parameters:
- DATA_WIDTH_P, 32, width of data, PC and target.
- NUM_SRC_P, 3, number of result sources (0=ALU, 1=load, 2=link PC+4); legal range 2..8.
- REG_ADDR_WIDTH_P, 5, register index width.
- FLUSH_CYCLES_P, 2, wrong-path instructions squashed after a redirect; legal range 0..15.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- wb_v_i  in  1  instruction valid from execute
- wb_ready_o  out  1  writeback can accept this cycle
- rd_we_i  in  1  instruction writes rd
- rd_addr_i  in  REG_ADDR_WIDTH_P  destination register
- src_sel_i  in  $clog2(NUM_SRC_P)  result source index
- src_data_i  in  NUM_SRC_P*DATA_WIDTH_P  packed sources; source k occupies bits [k*DATA_WIDTH_P +: DATA_WIDTH_P]
- br_v_i  in  1  conditional branch
- jmp_v_i  in  1  JAL/JALR
- bru_result_i  in  1  branch condition true
- target_i  in  DATA_WIDTH_P  branch/jump target
- stall_v_i  in  1  register-file port unavailable
- rf_w_v_o  out  1  register-file write enable
- rf_waddr_o  out  REG_ADDR_WIDTH_P  write address
- rf_wdata_o  out  DATA_WIDTH_P  write data
- redirect_v_o  out  1  redirect pulse
- redirect_pc_o  out  DATA_WIDTH_P  redirect target
- squash_o  out  1  FLUSH state active

Behaviour:
- Reset (synchronous, reset_i high at a clk_i edge):
  - State becomes RUN; output register invalid; flush counter 0.
  - rf_w_v_o=0, rf_waddr_o=0, rf_wdata_o=0, redirect_v_o=0, redirect_pc_o=0, squash_o=0.
  - Reset overrides any in-progress FLUSH or held write.
- Handshake:
  - Transfer occurs when wb_v_i && wb_ready_o.
  - wb_ready_o = ~stall_v_i || ~out_valid (one-entry output register).
- Write path:
  - On transfer in RUN, the output register captures:
    - valid = rd_we_i && (rd_addr_i != 0)
    - addr = rd_addr_i
    - data = source[src_sel_i]; src_sel_i >= NUM_SRC_P selects 0.
  - rf_w_v_o = out_valid && ~stall_v_i. Latency is one cycle from transfer to the write.
  - Under stall_v_i the register holds addr/data unchanged and rf_w_v_o=0.
  - The register clears when the write completes with no new transfer.
  - Back-to-back transfers with no stall give one write per cycle.
- Redirect:
  - taken = jmp_v_i || (br_v_i && bru_result_i), evaluated on a RUN transfer.
  - If taken: redirect_v_o=1 and redirect_pc_o=target_i for exactly the next cycle. The instruction's own write (jmp link) still occurs.
  - br_v_i && jmp_v_i together: treated as jump.
- FSM RUN/FLUSH:
  - RUN -> FLUSH on a taken transfer when FLUSH_CYCLES_P>0; counter loaded with FLUSH_CYCLES_P.
  - In FLUSH, squash_o=1 and transfers are accepted but produce no write and no redirect.
  - The counter decrements per squashed transfer; it does not decrement on idle cycles.
  - FLUSH -> RUN after the transfer that takes the counter to 0.
  - With FLUSH_CYCLES_P=0 the FSM stays in RUN.
- Boundary cases:
  - A taken branch during stall_v_i is still accepted if the register is free; the redirect is not delayed by the stall.
  - stall_v_i held indefinitely: no write and no data loss; wb_ready_o=0 while the register is full.

Optional Feature:
- WRITEBACK_RETIRE_CNT_EN:
  - When defined, adds output retire_cnt_o [31:0].
  - Increments once per non-squashed transfer, wraps at 2^32, and resets to 0.
  - When undefined, the port and counter are absent.

Decomposition:
- Shared package riscvga_pkg:
  - typedef wb_state_e {RUN, FLUSH}
  - Source index constants WB_SRC_ALU=0, WB_SRC_LOAD=1, WB_SRC_LINK=2
  - Packed struct wb_rf_write_s {v, addr, data}
- Sub-module writeback_src_mux (parametrised NUM_SRC_P/DATA_WIDTH_P one-of-N selector with out-of-range fallback to 0).

Test Plan:
- ALU op rd=5, src 0=0x1234, no stall -> next cycle rf_w_v_o=1, waddr=5, wdata=0x1234; no redirect.
- Write to rd=0 with rd_we_i=1 -> rf_w_v_o stays 0 while the transfer handshake still completes.
- stall_v_i high 3 cycles after a load to rd=7 data 0xDEAD -> wb_ready_o=0 and rf_w_v_o=0 for 3 cycles; write of 0xDEAD occurs the cycle stall drops.
- JAL with link 0x104, target 0x200, FLUSH_CYCLES_P=2 -> next cycle write 0x104 plus redirect_v_o=1 with pc 0x200; the next 2 transfers produce no writes and squash_o=1; the 3rd writes normally.
- Branch with bru_result_i=0 -> no redirect, state stays RUN; with bru_result_i=1 and target 0x80 -> single-cycle redirect to 0x80.
- reset_i asserted mid-FLUSH with a stalled write held -> next cycle all outputs 0, squash_o=0, wb_ready_o=1.

Source files
------------

// File: rtl/riscvga_pkg.sv
// riscvga_pkg: types and constants shared by the riscvga writeback stage.
//   wb_state_e    - writeback sequencing states (RUN, FLUSH)
//   WB_SRC_*      - result source indices into the packed source bus
//   wb_rf_write_s - register-file write record {v, addr, data}
package riscvga_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } wb_state_e;

  localparam int WB_SRC_ALU  = 0;
  localparam int WB_SRC_LOAD = 1;
  localparam int WB_SRC_LINK = 2;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef struct packed {
    logic                 v;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_rf_write_s;

endpackage

// File: rtl/writeback_unit_if.sv
// writeback_unit_if: execute-to-writeback bundle plus the register-file
// write and redirect outputs of the writeback stage.
//   master - execute/bench side: drives instruction fields, observes results
//   slave  - writeback_unit side
// Optional: WRITEBACK_RETIRE_CNT_EN adds retire_cnt_o [31:0].
interface writeback_unit_if #(
  parameter int DATA_WIDTH_P     = 32,
  parameter int NUM_SRC_P        = 3,
  parameter int REG_ADDR_WIDTH_P = 5
) ();

  localparam int SEL_W = $clog2(NUM_SRC_P);

  logic                              wb_v_i;
  logic                              wb_ready_o;
  logic                              rd_we_i;
  logic [REG_ADDR_WIDTH_P-1:0]       rd_addr_i;
  logic [SEL_W-1:0]                  src_sel_i;
  logic [NUM_SRC_P*DATA_WIDTH_P-1:0] src_data_i;
  logic                              br_v_i;
  logic                              jmp_v_i;
  logic                              bru_result_i;
  logic [DATA_WIDTH_P-1:0]           target_i;
  logic                              stall_v_i;
  logic                              rf_w_v_o;
  logic [REG_ADDR_WIDTH_P-1:0]       rf_waddr_o;
  logic [DATA_WIDTH_P-1:0]           rf_wdata_o;
  logic                              redirect_v_o;
  logic [DATA_WIDTH_P-1:0]           redirect_pc_o;
  logic                              squash_o;
`ifdef WRITEBACK_RETIRE_CNT_EN
  logic [31:0]                       retire_cnt_o;

  modport master (
    output wb_v_i, rd_we_i, rd_addr_i, src_sel_i, src_data_i,
           br_v_i, jmp_v_i, bru_result_i, target_i, stall_v_i,
    input  wb_ready_o, rf_w_v_o, rf_waddr_o, rf_wdata_o,
           redirect_v_o, redirect_pc_o, squash_o, retire_cnt_o
  );

  modport slave (
    input  wb_v_i, rd_we_i, rd_addr_i, src_sel_i, src_data_i,
           br_v_i, jmp_v_i, bru_result_i, target_i, stall_v_i,
    output wb_ready_o, rf_w_v_o, rf_waddr_o, rf_wdata_o,
           redirect_v_o, redirect_pc_o, squash_o, retire_cnt_o
  );
`else
  modport master (
    output wb_v_i, rd_we_i, rd_addr_i, src_sel_i, src_data_i,
           br_v_i, jmp_v_i, bru_result_i, target_i, stall_v_i,
    input  wb_ready_o, rf_w_v_o, rf_waddr_o, rf_wdata_o,
           redirect_v_o, redirect_pc_o, squash_o
  );

  modport slave (
    input  wb_v_i, rd_we_i, rd_addr_i, src_sel_i, src_data_i,
           br_v_i, jmp_v_i, bru_result_i, target_i, stall_v_i,
    output wb_ready_o, rf_w_v_o, rf_waddr_o, rf_wdata_o,
           redirect_v_o, redirect_pc_o, squash_o
  );
`endif

endinterface

// File: rtl/writeback_src_mux.sv
// writeback_src_mux: one-of-NUM_SRC_P result selector.
//   sel      - source index; values >= NUM_SRC_P fall back to the ALU source
//   src_data - packed sources, source k at [k*DATA_WIDTH_P +: DATA_WIDTH_P]
//   data     - selected value
module writeback_src_mux
  import riscvga_pkg::*;
#(
  parameter int NUM_SRC_P    = 3,
  parameter int DATA_WIDTH_P = 32
) (
  input  logic [$clog2(NUM_SRC_P)-1:0]       sel,
  input  logic [NUM_SRC_P*DATA_WIDTH_P-1:0]  src_data,
  output logic [DATA_WIDTH_P-1:0]            data
);

  localparam int SEL_W = $clog2(NUM_SRC_P);

  always_comb begin
    data = src_data[WB_SRC_ALU*DATA_WIDTH_P +: DATA_WIDTH_P];
    for (int k = 1; k < NUM_SRC_P; k++) begin
      if (sel == SEL_W'(k)) begin
        data = src_data[k*DATA_WIDTH_P +: DATA_WIDTH_P];
      end
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: riscvga writeback stage.
//   clk_i, reset_i (synchronous, active-high)
//   wb (slave)  - valid/ready instruction input from execute, result sources,
//                 branch/jump resolution, stall; register-file write,
//                 one-cycle redirect and squash outputs.
// A one-entry output register holds the pending write while the register
// file port is stalled. A taken branch/jump redirects for one cycle and then
// squashes the next FLUSH_CYCLES_P transfers.
// Optional: WRITEBACK_RETIRE_CNT_EN adds a 32-bit count of non-squashed
// transfers on retire_cnt_o.
//
// state | meaning
// RUN   | normal writeback, transfers write and may redirect
// FLUSH | wrong-path transfers accepted and dropped, counted down
module writeback_unit
  import riscvga_pkg::*;
#(
  parameter int DATA_WIDTH_P     = 32,
  parameter int NUM_SRC_P        = 3,
  parameter int REG_ADDR_WIDTH_P = 5,
  parameter int FLUSH_CYCLES_P   = 2
) (
  input logic             clk_i,
  input logic             reset_i,
  writeback_unit_if.slave wb
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]                  state;
  logic [3:0]                  flush_cnt;
  logic                        out_valid;
  logic [REG_ADDR_WIDTH_P-1:0] out_addr;
  logic [DATA_WIDTH_P-1:0]     out_data;
  logic                        redirect_v;
  logic [DATA_WIDTH_P-1:0]     redirect_pc;
  logic [DATA_WIDTH_P-1:0]     src_val;
  logic                        ready;
  logic                        xfer;
  logic                        run_xfer;
  logic                        taken;

  writeback_src_mux #(
    .NUM_SRC_P    (NUM_SRC_P),
    .DATA_WIDTH_P (DATA_WIDTH_P)
  ) u_src_mux (
    .sel      (wb.src_sel_i),
    .src_data (wb.src_data_i),
    .data     (src_val)
  );

  assign ready    = ~wb.stall_v_i | ~out_valid;
  assign xfer     = wb.wb_v_i & ready;
  assign run_xfer = xfer & (state == ST_RUN);
  // A jump wins over a simultaneous branch flag, so a not-taken condition
  // never suppresses it.
  assign taken    = wb.jmp_v_i | (wb.br_v_i & wb.bru_result_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= ST_RUN;
      flush_cnt   <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
      redirect_v  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect_v  <= run_xfer & taken;
      redirect_pc <= (run_xfer & taken) ? wb.target_i : '0;

      // Any transfer implies the held entry (if any) is draining this cycle,
      // so a squashed transfer simply leaves the register empty.
      if (run_xfer) begin
        out_valid <= wb.rd_we_i & (wb.rd_addr_i != '0);
        out_addr  <= wb.rd_addr_i;
        out_data  <= src_val;
      end else if (~wb.stall_v_i) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_RUN: begin
          if (run_xfer && taken && (FLUSH_CYCLES_P > 0)) begin
            state     <= ST_FLUSH;
            flush_cnt <= 4'(FLUSH_CYCLES_P);
          end
        end
        ST_FLUSH: begin
          if (xfer) begin
            flush_cnt <= flush_cnt - 4'd1;
            if (flush_cnt == 4'd1) begin
              state <= ST_RUN;
            end
          end
        end
        default: begin
          state     <= ST_RUN;
          flush_cnt <= '0;
        end
      endcase
    end
  end

  assign wb.wb_ready_o    = ready;
  assign wb.rf_w_v_o      = out_valid & ~wb.stall_v_i;
  assign wb.rf_waddr_o    = out_addr;
  assign wb.rf_wdata_o    = out_data;
  assign wb.redirect_v_o  = redirect_v;
  assign wb.redirect_pc_o = redirect_pc;
  assign wb.squash_o      = (state == ST_FLUSH);

`ifdef WRITEBACK_RETIRE_CNT_EN
  logic [31:0] retire_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      retire_cnt <= '0;
    end else if (run_xfer) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign wb.retire_cnt_o = retire_cnt;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed vector table for writeback_unit plus a
// hand-written long-stall sequence. Each row is driven after a falling edge
// and the outputs are compared 1 ns later, so expected values describe the
// cycle in which the row's inputs are applied.
//   chk 0 = no compare, 1 = compare (addr/data only when a write is expected),
//   2 = compare every output.
module tb_writeback_unit;
  import riscvga_pkg::*;

  localparam int DW = 32;
  localparam int NS = 3;
  localparam int AW = 5;
  localparam int NV = 35;

  logic clk = 1'b0;
  logic reset;

  initial forever #5 clk = ~clk;

  writeback_unit_if #(.DATA_WIDTH_P(DW), .NUM_SRC_P(NS), .REG_ADDR_WIDTH_P(AW)) wb_if ();

  writeback_unit #(
    .DATA_WIDTH_P     (DW),
    .NUM_SRC_P        (NS),
    .REG_ADDR_WIDTH_P (AW),
    .FLUSH_CYCLES_P   (2)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .wb      (wb_if)
  );

  typedef struct {
    int rst, v, we, addr, sel, alu, ld, lk, br, jmp, bru, tgt, stall;
    int chk, rdy, wv, wa, wd, rv, rpc, sq;
  } vec_t;

  vec_t vec [NV];
  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input int row, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      failures++;
      $display("FAIL %s row=%0d got=%0h exp=%0h", nm, row, got, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    logic [31:0] a, l, k, t, ad, sl;
    a = r.alu; l = r.ld; k = r.lk; t = r.tgt; ad = r.addr; sl = r.sel;
    reset                 = (r.rst != 0);
    wb_if.wb_v_i          = (r.v != 0);
    wb_if.rd_we_i         = (r.we != 0);
    wb_if.rd_addr_i       = ad[AW-1:0];
    wb_if.src_sel_i       = sl[1:0];
    wb_if.src_data_i      = {k, l, a};
    wb_if.br_v_i          = (r.br != 0);
    wb_if.jmp_v_i         = (r.jmp != 0);
    wb_if.bru_result_i    = (r.bru != 0);
    wb_if.target_i        = t;
    wb_if.stall_v_i       = (r.stall != 0);
  endtask

  task automatic compare(input int i, input vec_t r);
    check("ready", i, 32'(wb_if.wb_ready_o), r.rdy);
    check("rf_w_v", i, 32'(wb_if.rf_w_v_o), r.wv);
    check("redirect_v", i, 32'(wb_if.redirect_v_o), r.rv);
    check("squash", i, 32'(wb_if.squash_o), r.sq);
    if (r.wv != 0 || r.chk == 2) begin
      check("rf_waddr", i, 32'(wb_if.rf_waddr_o), r.wa);
      check("rf_wdata", i, wb_if.rf_wdata_o, r.wd);
    end
    if (r.rv != 0 || r.chk == 2) begin
      check("redirect_pc", i, wb_if.redirect_pc_o, r.rpc);
    end
  endtask

  initial begin
    vec_t idle;
    // rst v we addr sel alu ld lk br jmp bru tgt stall | chk rdy wv wa wd rv rpc sq
    vec[0]  = '{1,0,0,0,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,0,0,0};
    vec[1]  = '{1,0,0,0,0,0,0,0,0,0,0,0,0,        2,1,0,0,0,0,0,0};
    vec[2]  = '{0,1,1,5,0,'h1234,'h1111,'h2222,0,0,0,0,0, 2,1,0,0,0,0,0,0};
    vec[3]  = '{0,0,0,0,0,0,0,0,0,0,0,0,0,        1,1,1,5,'h1234,0,0,0};
    vec[4]  = '{0,1,1,0,0,'h5555,0,0,0,0,0,0,0,   1,1,0,0,0,0,0,0};
    vec[5]  = '{0,0,0,0,0,0,0,0,0,0,0,0,0,        1,1,0,0,0,0,0,0};
    vec[6]  = '{0,1,1,7,1,'h9,'hDEAD,0,0,0,0,0,0, 1,1,0,0,0,0,0,0};
    vec[7]  = '{0,0,0,0,0,0,0,0,0,0,0,0,1,        2,0,0,7,'hDEAD,0,0,0};
    vec[8]  = '{0,1,1,9,0,'hBAD,0,0,0,0,0,0,1,    2,0,0,7,'hDEAD,0,0,0};
    vec[9]  = '{0,0,0,0,0,0,0,0,0,0,0,0,1,        2,0,0,7,'hDEAD,0,0,0};
    vec[10] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,        1,1,1,7,'hDEAD,0,0,0};
    vec[11] = '{0,1,1,3,0,'hA1,0,0,0,0,0,0,0,     1,1,0,0,0,0,0,0};
    vec[12] = '{0,1,1,4,2,0,0,'hA2,0,0,0,0,0,     1,1,1,3,'hA1,0,0,0};
    vec[13] = '{0,1,1,6,3,'hA3,'hFF,'hEE,0,0,0,0,0, 1,1,1,4,'hA2,0,0,0};
    vec[14] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,        1,1,1,6,'hA3,0,0,0};
    vec[15] = '{0,1,0,0,0,0,0,0,1,0,0,'h80,0,     1,1,0,0,0,0,0,0};
    vec[16] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,        1,1,0,0,0,0,0,0};
    vec[17] = '{0,1,0,0,0,0,0,0,1,0,1,'h80,0,     1,1,0,0,0,0,0,0};
    vec[18] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,        1,1,0,0,0,1,'h80,1};
    vec[19] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,        1,1,0,0,0,0,0,1};
    vec[20] = '{0,1,1,8,0,'h11,0,0,0,0,0,0,0,     1,1,0,0,0,0,0,1};
    vec[21] = '{0,1,1,9,0,'h22,0,0,0,0,0,0,0,     1,1,0,0,0,0,0,1};
    vec[22] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,        1,1,0,0,0,0,0,0};
    vec[23] = '{0,1,1,1,2,0,0,'h104,0,1,0,'h200,0, 1,1,0,0,0,0,0,0};
    vec[24] = '{0,1,1,10,0,'h33,0,0,0,0,0,0,0,    1,1,1,1,'h104,1,'h200,1};
    vec[25] = '{0,1,1,11,0,'h34,0,0,0,0,0,0,0,    1,1,0,0,0,0,0,1};
    vec[26] = '{0,1,1,12,0,'h44,0,0,0,0,0,0,0,    1,1,0,0,0,0,0,0};
    vec[27] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,        1,1,1,12,'h44,0,0,0};
    vec[28] = '{0,1,1,2,0,'h55,0,0,1,0,1,'h300,1, 1,1,0,0,0,0,0,0};
    vec[29] = '{0,0,0,0,0,0,0,0,0,0,0,0,1,        1,0,0,0,0,1,'h300,1};
    vec[30] = '{0,0,0,0,0,0,0,0,0,0,0,0,1,        1,0,0,0,0,0,0,1};
    vec[31] = '{1,0,0,0,0,0,0,0,0,0,0,0,1,        1,0,0,0,0,0,0,1};
    vec[32] = '{0,0,0,0,0,0,0,0,0,0,0,0,1,        2,1,0,0,0,0,0,0};
    vec[33] = '{0,1,1,1,2,0,0,'h8,1,1,0,'h400,0,  2,1,0,0,0,0,0,0};
    vec[34] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,        1,1,1,1,'h8,1,'h400,1};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vec[i]);
      #1;
      if (vec[i].chk != 0) compare(i, vec[i]);
    end

    // Long stall: a held load must survive 20 stalled cycles intact.
    idle = '{1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
    @(negedge clk);
    drive(idle);
    idle.rst = 0;
    @(negedge clk);
    drive('{0,1,1,13,WB_SRC_LOAD,'h1,'hCAFE,'h2,0,0,0,0,0, 0,0,0,0,0,0,0,0});
    @(negedge clk);
    idle.stall = 1;
    drive(idle);
    for (int c = 0; c < 20; c++) begin
      #1;
      check("long_stall_ready", 100 + c, 32'(wb_if.wb_ready_o), 0);
      check("long_stall_rf_w_v", 100 + c, 32'(wb_if.rf_w_v_o), 0);
      @(negedge clk);
    end
    idle.stall = 0;
    drive(idle);
    #1;
    check("long_stall_release_v", 120, 32'(wb_if.rf_w_v_o), 1);
    check("long_stall_release_addr", 120, 32'(wb_if.rf_waddr_o), 13);
    check("long_stall_release_data", 120, wb_if.rf_wdata_o, 'hCAFE);
    @(negedge clk);
    #1;
    check("long_stall_drained", 121, 32'(wb_if.rf_w_v_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
